// File: rtl/camera_frame_sequencer_if.sv
// Byte stream from the camera UART receiver into the frame sequencer.
interface camera_frame_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    // master: UART receiver side, slave: sequencer side
    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/camera_frame_sequencer.sv
// Camera frame sequencer: finds the 0xFF sync header, collects the 6-byte
// payload, range-checks the two marker positions and presents the last
// good coordinates with a one-cycle frame_valid strobe. It also tracks
// stale input, frame/error counts and inter-byte timeouts.
module camera_frame_sequencer #(
    parameter int         SYNC_BYTES   = 3,
    parameter logic [11:0] X_MAX       = 12'h274,
    parameter logic [11:0] Y_MAX       = 12'h1DF,
    parameter int         BYTE_TIMEOUT = 65000,
    parameter int         STALE_CYCLES = 6500000
) (
    input  logic                     clk_65mhz,
    input  logic                     sys_rst,
    camera_frame_sequencer_if.slave  rx,
    output logic [11:0]              x_top,
    output logic [11:0]              y_top,
    output logic [11:0]              x_bottom,
    output logic [11:0]              y_bottom,
    output logic                     frame_valid,
    output logic                     stale,
    output logic [15:0]              frame_count,
    output logic [7:0]               err_count
);

    localparam int SW = $clog2(SYNC_BYTES + 1);
    localparam int IW = $clog2(BYTE_TIMEOUT + 1);
    localparam int TW = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [5:0][7:0]  pay_q, pay_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [TW-1:0]    stale_cnt_q, stale_cnt_d;
    logic [11:0]      x_top_q, x_top_d, y_top_q, y_top_d;
    logic [11:0]      x_bottom_q, x_bottom_d, y_bottom_q, y_bottom_d;
    logic             frame_valid_q, frame_valid_d;
    logic             stale_q, stale_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [7:0]       err_count_q, err_count_d;

    // Coordinates as laid out in the payload (12-bit values split over 1.5 bytes)
    logic [11:0] dec_xt, dec_yt, dec_xb, dec_yb;
    logic        ok_xt, ok_yt, ok_xb, ok_yb;

    assign dec_xt = {pay_q[0], pay_q[2][7:4]};
    assign dec_yt = {pay_q[2][3:0], pay_q[1]};
    assign dec_xb = {pay_q[3], pay_q[5][7:4]};
    assign dec_yb = {pay_q[5][3:0], pay_q[4]};
    assign ok_xt  = (dec_xt <= X_MAX);
    assign ok_yt  = (dec_yt <= Y_MAX);
    assign ok_xb  = (dec_xb <= X_MAX);
    assign ok_yb  = (dec_yb <= Y_MAX);

    // Next-state, payload capture, counters and output register updates
    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        byte_idx_d    = byte_idx_q;
        pay_d         = pay_q;
        idle_d        = idle_q;
        x_top_d       = x_top_q;
        y_top_d       = y_top_q;
        x_bottom_d    = x_bottom_q;
        y_bottom_d    = y_bottom_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        // Stale counter free-runs (saturating) except on CHECK
        stale_cnt_d   = (stale_cnt_q == TW'(STALE_CYCLES)) ? stale_cnt_q
                                                           : stale_cnt_q + TW'(1);

        unique case (state_q)
            HUNT: begin
                idle_d = '0;
                if (rx.rx_valid) begin
                    if (sync_cnt_q == SW'(SYNC_BYTES)) begin
                        // Header complete: this byte is B0 regardless of value
                        pay_d[0]   = rx.rx_data;
                        byte_idx_d = 3'd1;
                        sync_cnt_d = '0;
                        state_d    = PAYLOAD;
                    end else if (rx.rx_data == 8'hFF) begin
                        sync_cnt_d = sync_cnt_q + SW'(1);
                    end else begin
                        sync_cnt_d = '0;
                    end
                end
            end

            PAYLOAD: begin
                if (rx.rx_valid) begin
                    pay_d[byte_idx_q] = rx.rx_data;
                    idle_d            = '0;
                    if (byte_idx_q == 3'd5) begin
                        byte_idx_d = 3'd0;
                        state_d    = CHECK;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end else if (idle_q == IW'(BYTE_TIMEOUT - 1)) begin
                    // Link went quiet mid-frame: drop the partial payload
                    state_d     = HUNT;
                    sync_cnt_d  = '0;
                    byte_idx_d  = 3'd0;
                    idle_d      = '0;
                    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end

            CHECK: begin
                if (ok_xt) x_top_d    = dec_xt;
                if (ok_yt) y_top_d    = dec_yt;
                if (ok_xb) x_bottom_d = dec_xb;
                if (ok_yb) y_bottom_d = dec_yb;
                if (!(ok_xt && ok_yt && ok_xb && ok_yb))
                    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                frame_count_d = frame_count_q + 16'd1;
                frame_valid_d = 1'b1;
                stale_cnt_d   = '0;
                state_d       = HUNT;
                // A byte landing during CHECK already counts toward the next header
                sync_cnt_d    = (rx.rx_valid && rx.rx_data == 8'hFF) ? SW'(1) : '0;
            end

            default: begin
                state_d    = HUNT;
                sync_cnt_d = '0;
                byte_idx_d = 3'd0;
            end
        endcase

        stale_d = (stale_cnt_d >= TW'(STALE_CYCLES));
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk_65mhz) begin
        if (sys_rst) begin
            state_q       <= HUNT;
            sync_cnt_q    <= '0;
            byte_idx_q    <= 3'd0;
            pay_q         <= '0;
            idle_q        <= '0;
            stale_cnt_q   <= TW'(STALE_CYCLES);
            x_top_q       <= '0;
            y_top_q       <= '0;
            x_bottom_q    <= '0;
            y_bottom_q    <= '0;
            frame_valid_q <= 1'b0;
            stale_q       <= 1'b1;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            byte_idx_q    <= byte_idx_d;
            pay_q         <= pay_d;
            idle_q        <= idle_d;
            stale_cnt_q   <= stale_cnt_d;
            x_top_q       <= x_top_d;
            y_top_q       <= y_top_d;
            x_bottom_q    <= x_bottom_d;
            y_bottom_q    <= y_bottom_d;
            frame_valid_q <= frame_valid_d;
            stale_q       <= stale_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign x_top       = x_top_q;
    assign y_top       = y_top_q;
    assign x_bottom    = x_bottom_q;
    assign y_bottom    = y_bottom_q;
    assign frame_valid = frame_valid_q;
    assign stale       = stale_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_camera_frame_sequencer.sv
// Bench for camera_frame_sequencer: table of frames plus hand sequences for
// timeout, staleness, error saturation and mid-frame reset. Expected frame
// results are queued when a frame is sent and compared on frame_valid.
module tb_camera_frame_sequencer;

    localparam int BT = 40;
    localparam int SC = 300;

    logic        clk_65mhz = 1'b0;
    logic        sys_rst   = 1'b1;
    logic [11:0] x_top, y_top, x_bottom, y_bottom;
    logic        frame_valid, stale;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk_65mhz = ~clk_65mhz;

    camera_frame_sequencer_if rx_if();

    camera_frame_sequencer #(
        .SYNC_BYTES(3), .X_MAX(12'h274), .Y_MAX(12'h1DF),
        .BYTE_TIMEOUT(BT), .STALE_CYCLES(SC)
    ) dut (
        .clk_65mhz   (clk_65mhz),
        .sys_rst     (sys_rst),
        .rx          (rx_if),
        .x_top       (x_top),
        .y_top       (y_top),
        .x_bottom    (x_bottom),
        .y_bottom    (y_bottom),
        .frame_valid (frame_valid),
        .stale       (stale),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    typedef struct {
        logic [0:11][7:0] b;
        int               n;
        logic [11:0]      xt, yt, xb, yb;
        logic [7:0]       err;
        logic [15:0]      fc;
    } vec_t;

    typedef struct {
        logic [11:0] xt, yt, xb, yb;
        logic [7:0]  err;
        logic [15:0] fc;
    } exp_t;

    vec_t tbl[6];
    exp_t sb_q[$];
    exp_t cur;

    logic [0:11][7:0] good_f, bad_f, part_f, rest_f;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] xt, yt, xb, yb,
                                input logic [7:0] err, input logic [15:0] fc);
        exp_t e;
        e.xt = xt; e.yt = yt; e.xb = xb; e.yb = yb; e.err = err; e.fc = fc;
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        sb_q.push_back(e);
        cur = e;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        @(posedge clk_65mhz); #1;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [0:11][7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic idle(input int n);
        rx_if.rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_65mhz); #1;
        end
    endtask

    // Frame_valid must be low during CHECK, high the next cycle, then low
    task automatic check_latency(input string tag);
        @(negedge clk_65mhz); chk({tag, "_fv_check_cycle"}, frame_valid, 1'b0);
        @(negedge clk_65mhz); chk({tag, "_fv_pulse"},       frame_valid, 1'b1);
        @(negedge clk_65mhz); chk({tag, "_fv_one_cycle"},   frame_valid, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x_top"},       x_top,       12'h0);
        chk({tag, "_y_top"},       y_top,       12'h0);
        chk({tag, "_x_bottom"},    x_bottom,    12'h0);
        chk({tag, "_y_bottom"},    y_bottom,    12'h0);
        chk({tag, "_frame_valid"}, frame_valid, 1'b0);
        chk({tag, "_stale"},       stale,       1'b1);
        chk({tag, "_frame_count"}, frame_count, 16'h0);
        chk({tag, "_err_count"},   err_count,   8'h0);
    endtask

    // Scoreboard: every frame_valid pulse consumes one queued expectation
    always @(negedge clk_65mhz) begin
        if (frame_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_frame_valid got=1 want=0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_x_top",       x_top,       e.xt);
                chk("sb_y_top",       y_top,       e.yt);
                chk("sb_x_bottom",    x_bottom,    e.xb);
                chk("sb_y_bottom",    y_bottom,    e.yb);
                chk("sb_err_count",   err_count,   e.err);
                chk("sb_frame_count", frame_count, e.fc);
                chk("sb_stale_clear", stale,       1'b0);
            end
        end
    end

    initial begin
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;

        good_f = {8'hFF,8'hFF,8'hFF,8'h12,8'h34,8'h51,8'h20,8'h80,8'h31,8'h00,8'h00,8'h00};
        bad_f  = {8'hFF,8'hFF,8'hFF,8'h30,8'h34,8'h01,8'h20,8'h80,8'h31,8'h00,8'h00,8'h00};
        part_f = {8'hFF,8'hFF,8'hFF,8'h12,8'h34,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        rest_f = {8'h51,8'h20,8'h80,8'h31,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};

        // Frames from reset, with expected results in sequence
        tbl[0] = '{b: good_f, n: 9, xt: 12'h125, yt: 12'h134, xb: 12'h203, yb: 12'h180, err: 8'd0, fc: 16'd1};
        tbl[1] = '{b: bad_f,  n: 9, xt: 12'h125, yt: 12'h134, xb: 12'h203, yb: 12'h180, err: 8'd1, fc: 16'd2};
        // Top exactly at limits (accepted), bottom one past limits (held)
        tbl[2] = '{b: {8'hFF,8'hFF,8'hFF,8'h27,8'hDF,8'h41,8'h27,8'hE0,8'h51,8'h00,8'h00,8'h00},
                   n: 9, xt: 12'h274, yt: 12'h1DF, xb: 12'h203, yb: 12'h180, err: 8'd2, fc: 16'd3};
        tbl[3] = '{b: {8'hFF,8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                   n: 9, xt: 12'h000, yt: 12'h000, xb: 12'h000, yb: 12'h000, err: 8'd2, fc: 16'd4};
        // 0xFF right after the header is payload B0 (x_top 0xFF0 fails, holds 0)
        tbl[4] = '{b: {8'hFF,8'hFF,8'hFF,8'hFF,8'h10,8'h01,8'h11,8'h22,8'h31,8'h00,8'h00,8'h00},
                   n: 9, xt: 12'h000, yt: 12'h110, xb: 12'h113, yb: 12'h122, err: 8'd3, fc: 16'd5};
        // Broken header followed by a good frame
        tbl[5] = '{b: {8'hFF,8'hFF,8'h00,8'hFF,8'hFF,8'hFF,8'h12,8'h34,8'h51,8'h20,8'h80,8'h31},
                   n: 12, xt: 12'h125, yt: 12'h134, xb: 12'h203, yb: 12'h180, err: 8'd3, fc: 16'd6};

        repeat (3) @(posedge clk_65mhz);
        #1 sys_rst = 1'b0;
        @(negedge clk_65mhz);
        check_reset_vals("reset");
        idle(1);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            push_exp(mk(tbl[i].xt, tbl[i].yt, tbl[i].xb, tbl[i].yb, tbl[i].err, tbl[i].fc));
            send_bytes(tbl[i].b, tbl[i].n);
            check_latency($sformatf("row%0d", i));
            idle(3);
        end

        // Inter-byte timeout aborts the frame and counts an error
        send_bytes(part_f, 5);
        idle(BT + 5);
        @(negedge clk_65mhz);
        chk("timeout_err_count",   err_count,   cur.err + 8'd1);
        chk("timeout_frame_count", frame_count, cur.fc);
        cur.err = cur.err + 8'd1;
        idle(2);

        // A gap just under the timeout still completes the frame
        push_exp(mk(12'h125, 12'h134, 12'h203, 12'h180, cur.err, cur.fc + 16'd1));
        send_bytes(part_f, 5);
        idle(BT - 3);
        send_bytes(rest_f, 4);
        check_latency("near_timeout");
        idle(2);

        // Staleness rises exactly STALE_CYCLES after the last frame_valid
        push_exp(mk(12'h125, 12'h134, 12'h203, 12'h180, cur.err, cur.fc + 16'd1));
        send_bytes(good_f, 9);
        @(negedge clk_65mhz);
        @(negedge clk_65mhz); chk("stale_frame_valid", frame_valid, 1'b1);
        repeat (SC - 1) @(negedge clk_65mhz);
        chk("stale_before_limit", stale, 1'b0);
        @(negedge clk_65mhz);
        chk("stale_at_limit", stale, 1'b1);
        idle(1);
        push_exp(mk(12'h125, 12'h134, 12'h203, 12'h180, cur.err, cur.fc + 16'd1));
        send_bytes(good_f, 9);
        check_latency("stale_clear");
        chk("stale_after_frame", stale, 1'b0);
        idle(2);

        // Enough bad frames to saturate the error counter
        for (int k = 0; k < 256; k++) begin
            push_exp(mk(cur.xt, 12'h134, 12'h203, 12'h180,
                        (cur.err == 8'hFF) ? 8'hFF : cur.err + 8'd1, cur.fc + 16'd1));
            send_bytes(bad_f, 9);
            idle(3);
        end
        @(negedge clk_65mhz);
        chk("err_saturated", err_count, 8'hFF);
        chk("bad_frames_all_seen", sb_q.size(), 0);
        idle(1);

        // Reset mid-payload discards the partial frame
        send_bytes(part_f, 5);
        sys_rst = 1'b1;
        @(posedge clk_65mhz); #1;
        sys_rst = 1'b0;
        @(negedge clk_65mhz);
        check_reset_vals("midrst");
        idle(1);
        send_bytes(rest_f, 4);
        idle(6);
        @(negedge clk_65mhz);
        chk("midrst_no_frame", frame_count, 16'h0);
        idle(1);
        push_exp(mk(12'h125, 12'h134, 12'h203, 12'h180, 8'd0, 16'd1));
        send_bytes(good_f, 9);
        check_latency("post_rst");
        idle(3);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
